// File: rtl/heart_seq_ctrl.sv
// rtl/heart_seq_ctrl.sv - DDS segment sequencer: programmable freq/amp/duration table with one-shot or looped playback
module heart_seq_ctrl #(
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 16,
  parameter int DUR_W   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [DUR_W-1:0]   cfg_dur,
  input  logic               cfg_last,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [PHASE_W-1:0] freq_word,
  output logic [AMP_W-1:0]   amp,
  output logic               dds_en,
  output logic [ADDR_W-1:0]  seg_idx,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic               last;
    logic [DUR_W-1:0]   dur;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] freq;
  } entry_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

  state_t             state_q, state_d;
  entry_t             tbl_q [DEPTH];
  entry_t             tbl_d [DEPTH];
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  seg_idx_q, seg_idx_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic               first_q, first_d;
  logic               cfg_err_q, cfg_err_d;
  logic               busy_c;
  logic               dds_en_c;
  logic               done_c;
  entry_t             cur_entry;
  entry_t             wr_entry;

  assign cur_entry = tbl_q[idx_q];
  assign wr_entry  = '{last: cfg_last, dur: cfg_dur, amp: cfg_amp, freq: cfg_freq};

  // Table update: writes land only while no sequence is playing; a blocked write raises cfg_err next cycle
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (busy_c) begin
        cfg_err_d = 1'b1;
      end else begin
        tbl_d[cfg_addr] = wr_entry;
      end
    end
  end

  // Table storage, cleared by reset so an unprogrammed entry plays as freq 0, amp 0, one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      cfg_err_q <= cfg_err_d;
    end
  end

  // Playback next-state and outputs; stop overrides everything while a sequence is active
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seg_idx_d = seg_idx_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    amp_d     = amp_q;
    first_d   = first_q;
    busy_c    = 1'b0;
    dds_en_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          idx_d   = '0;
          first_d = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy_c   = 1'b1;
        // carrier stays on between segments; only the very first fetch has the DDS gated
        dds_en_c = !first_q;
        if (stop) begin
          amp_d   = '0;
          state_d = ST_IDLE;
        end else begin
          freq_d    = cur_entry.freq;
          amp_d     = cur_entry.amp;
          cnt_d     = (cur_entry.dur == '0) ? DUR_ONE : cur_entry.dur;
          seg_idx_d = idx_q;
          first_d   = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c   = 1'b1;
        dds_en_c = 1'b1;
        if (stop) begin
          amp_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - DUR_ONE;
          if (cnt_q == DUR_ONE) begin
            if (!cur_entry.last && (idx_q != LAST_IDX)) begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = ST_LOAD;
            end else if (loop_en) begin
              idx_d   = '0;
              state_d = ST_LOAD;
            end else begin
              amp_d   = '0;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      seg_idx_q <= '0;
      cnt_q     <= '0;
      freq_q    <= '0;
      amp_q     <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seg_idx_q <= seg_idx_d;
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      first_q   <= first_d;
    end
  end

  assign freq_word = freq_q;
  assign amp       = amp_q;
  assign dds_en    = dds_en_c;
  assign seg_idx   = seg_idx_q;
  assign busy      = busy_c;
  assign done      = done_c;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_heart_seq_ctrl.sv
// tb/tb_heart_seq_ctrl.sv - self-checking bench for heart_seq_ctrl
module tb_heart_seq_ctrl;
  localparam int PHASE_W = 24;
  localparam int AMP_W   = 16;
  localparam int DUR_W   = 16;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cfg_we = 1'b0;
  logic [ADDR_W-1:0]  cfg_addr = '0;
  logic [PHASE_W-1:0] cfg_freq = '0;
  logic [AMP_W-1:0]   cfg_amp = '0;
  logic [DUR_W-1:0]   cfg_dur = '0;
  logic               cfg_last = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop_en = 1'b0;
  logic [PHASE_W-1:0] freq_word;
  logic [AMP_W-1:0]   amp;
  logic               dds_en;
  logic [ADDR_W-1:0]  seg_idx;
  logic               busy;
  logic               done;
  logic               cfg_err;

  heart_seq_ctrl #(.PHASE_W(PHASE_W), .AMP_W(AMP_W), .DUR_W(DUR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_freq(cfg_freq),
    .cfg_amp(cfg_amp), .cfg_dur(cfg_dur), .cfg_last(cfg_last), .start(start), .stop(stop),
    .loop_en(loop_en), .freq_word(freq_word), .amp(amp), .dds_en(dds_en), .seg_idx(seg_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected output frame for one cycle; playback is modelled as a queue of such frames
  typedef struct {
    logic [PHASE_W-1:0] freq;
    logic [AMP_W-1:0]   amp;
    logic [ADDR_W-1:0]  idx;
    logic               en;
    logic               busy;
    logic               done;
    logic               last_run;
    int                 seg;
  } frame_t;

  typedef struct {
    logic [PHASE_W-1:0] freq;
    logic [AMP_W-1:0]   amp;
    int                 dur;
    logic               last;
  } ent_t;

  ent_t   m_tbl [DEPTH];
  frame_t cur;
  frame_t fq[$];
  logic   m_err;

  function automatic frame_t zero_frame();
    frame_t r;
    r.freq = '0; r.amp = '0; r.idx = '0; r.en = 1'b0; r.busy = 1'b0;
    r.done = 1'b0; r.last_run = 1'b0; r.seg = 0;
    return r;
  endfunction

  function automatic frame_t idle_of(frame_t f, logic d);
    frame_t r = f;
    r.amp = '0; r.en = 1'b0; r.busy = 1'b0; r.done = d; r.last_run = 1'b0;
    return r;
  endfunction

  // Queue one segment: a fetch cycle showing the previous values, then max(dur,1) play cycles
  task automatic push_seg(int k, logic first);
    frame_t f;
    int n;
    f = cur;
    f.en = !first; f.busy = 1'b1; f.done = 1'b0; f.last_run = 1'b0;
    fq.push_back(f);
    n = (m_tbl[k].dur == 0) ? 1 : m_tbl[k].dur;
    for (int i = 0; i < n; i++) begin
      f.freq = m_tbl[k].freq; f.amp = m_tbl[k].amp; f.idx = ADDR_W'(k);
      f.en = 1'b1; f.busy = 1'b1; f.last_run = (i == n - 1); f.seg = k;
      fq.push_back(f);
    end
  endtask

  frame_t nxt;
  logic   err_n;
  int     mk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_tbl[i].freq = '0; m_tbl[i].amp = '0; m_tbl[i].dur = 0; m_tbl[i].last = 1'b0;
      end
      fq.delete();
      cur = zero_frame();
      m_err = 1'b0;
    end else begin
      err_n = cfg_we && cur.busy;
      if (cfg_we && !cur.busy) begin
        m_tbl[cfg_addr].freq = cfg_freq; m_tbl[cfg_addr].amp = cfg_amp;
        m_tbl[cfg_addr].dur = int'(cfg_dur); m_tbl[cfg_addr].last = cfg_last;
      end
      if ((cur.busy || cur.done) && stop) begin
        fq.delete();
        nxt = idle_of(cur, 1'b0);
      end else if (fq.size() > 0) begin
        nxt = fq.pop_front();
      end else if (cur.last_run) begin
        mk = cur.seg;
        if (!m_tbl[mk].last && mk != DEPTH - 1) begin
          push_seg(mk + 1, 1'b0);
          nxt = fq.pop_front();
        end else if (loop_en) begin
          push_seg(0, 1'b0);
          nxt = fq.pop_front();
        end else begin
          nxt = idle_of(cur, 1'b1);
        end
      end else if (!cur.done && start && !stop) begin
        push_seg(0, 1'b1);
        nxt = fq.pop_front();
      end else begin
        nxt = idle_of(cur, 1'b0);
      end
      cur = nxt;
      m_err = err_n;
    end
  end

  // Compare every cycle against the model
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (freq_word !== cur.freq || amp !== cur.amp || seg_idx !== cur.idx || dds_en !== cur.en ||
          busy !== cur.busy || done !== cur.done || cfg_err !== m_err) begin
        errors++;
        $display("FAIL model t=%0t got f=%0d a=%0h i=%0d en=%b b=%b d=%b e=%b exp f=%0d a=%0h i=%0d en=%b b=%b d=%b e=%b",
                 $time, freq_word, amp, seg_idx, dds_en, busy, done, cfg_err,
                 cur.freq, cur.amp, cur.idx, cur.en, cur.busy, cur.done, m_err);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, int f, int am, int d, logic l);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_freq = PHASE_W'(f);
    cfg_amp = AMP_W'(am); cfg_dur = DUR_W'(d); cfg_last = l;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_seg1();
    for (int i = 0; i < 60 && !(busy && seg_idx == 1); i++) tick(1);
    chk("reach_seg1", 32'(busy && seg_idx == 1), 32'd1);
  endtask

  int n, lows, dn;

  initial begin
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_freq", 32'(freq_word), 0);
    chk("rst_en", 32'(dds_en), 0);

    wr(0, 1678, 'h4000, 5, 1'b0);
    wr(1, 168, 'h8000, 3, 1'b0);
    wr(2, 1678, 'h2000, 2, 1'b1);

    go();
    chk("load_en", 32'(dds_en), 0);
    chk("load_busy", 32'(busy), 1);
    tick(1);
    chk("run0_en", 32'(dds_en), 1);
    chk("run0_freq", 32'(freq_word), 1678);
    chk("run0_amp", 32'(amp), 'h4000);
    busy_len(n);
    chk("oneshot_busy", 32'(n + 1), 13);
    chk("oneshot_done", 32'(done), 1);
    chk("oneshot_idx", 32'(seg_idx), 2);
    tick(1);
    chk("done_once", 32'(done), 0);

    loop_en = 1'b1;
    go();
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (!dds_en) lows++;
    end
    chk("loop_no_gap", 32'(lows), 0);
    wait_seg1();
    loop_en = 1'b0;
    busy_len(n);
    chk("loop_tail", 32'(n), 6);
    chk("loop_exit_done", 32'(done), 1);
    chk("loop_exit_idx", 32'(seg_idx), 2);
    tick(1);

    go();
    wait_seg1();
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_amp", 32'(amp), 0);
    chk("stop_en", 32'(dds_en), 0);
    chk("stop_freq", 32'(freq_word), 168);
    chk("stop_idx", 32'(seg_idx), 1);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      tick(1);
    end
    chk("stop_no_done", 32'(dn), 0);

    wr(0, 5000, 'h1000, 0, 1'b1);
    go();
    busy_len(n);
    chk("dur0_busy", 32'(n), 2);
    chk("dur0_done", 32'(done), 1);
    tick(1);

    for (int i = 0; i < DEPTH; i++) wr(i, 1000 + i * 10, 'h100 * (i + 1), i, 1'b0);
    go();
    busy_len(n);
    chk("nolast_busy", 32'(n), 37);
    chk("nolast_idx", 32'(seg_idx), 7);
    chk("nolast_done", 32'(done), 1);
    tick(1);

    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", 32'(busy), 0);
    tick(1);
    chk("startstop_idle2", 32'(busy), 0);

    go();
    tick(2);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_freq = 24'h0ABCDE; cfg_amp = 16'h7777;
    cfg_dur = 16'd9; cfg_last = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    tick(1);
    chk("cfg_err_once", 32'(cfg_err), 0);
    busy_len(n);
    tick(1);
    go();
    wait_seg1();
    chk("cfg_kept_freq", 32'(freq_word), 1010);
    chk("cfg_kept_amp", 32'(amp), 'h200);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_en", 32'(dds_en), 0);
    chk("arst_amp", 32'(amp), 0);
    chk("arst_freq", 32'(freq_word), 0);
    chk("arst_idx", 32'(seg_idx), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    go();
    tick(1);
    chk("clr_freq", 32'(freq_word), 0);
    chk("clr_en", 32'(dds_en), 1);
    busy_len(n);
    chk("clr_busy", 32'(n + 1), 16);
    chk("clr_idx", 32'(seg_idx), 7);
    chk("clr_done", 32'(done), 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/heart_seq_ctrl.md
Name: heart_seq_ctrl

Overview:
- Segment sequencer for the DDS carrier/envelope datapath.
- Holds a small programmable table of segments; each segment is a frequency word, an amplitude scale and a duration.
- On start, plays the segments in order and drives the DDS FreqWord, ClkEn and the envelope amplitude multiplier.
- Supports one-shot or looped playback, with a busy/done handshake toward the system controller.

Parameters:
- PHASE_W, 24, width of frequency word (matches DDS PHASE_W)
- AMP_W, 16, width of amplitude scale word
- DUR_W, 16, width of segment duration counter (clk cycles)
- DEPTH, 8, number of table entries (power of two)
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  table entry index
- cfg_freq  in  PHASE_W  segment frequency word
- cfg_amp  in  AMP_W  segment amplitude scale
- cfg_dur  in  DUR_W  segment length in RUN cycles (0 treated as 1)
- cfg_last  in  1  entry terminates the sequence
- start  in  1  level-sampled start request
- stop  in  1  abort request
- loop_en  in  1  wrap to entry 0 after the terminating entry
- freq_word  out  PHASE_W  DDS FreqWord
- amp  out  AMP_W  envelope scale to multiplier
- dds_en  out  1  DDS ClkEn
- seg_idx  out  ADDR_W  current entry index
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on natural completion
- cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset values: all outputs 0; state IDLE; all table fields 0, including last.
- Table writes:
  - Accepted only when busy=0; the entry is updated at the edge.
  - cfg_we while busy=1 is ignored, and cfg_err pulses on the next cycle.
- States are IDLE, LOAD, RUN and DONE.
- IDLE:
  - busy=0, dds_en=0, amp=0; freq_word holds its last value.
  - start=1 and stop=0 at an edge: idx←0, go to LOAD.
- LOAD (one cycle):
  - busy=1; reads entry[idx].
  - At the end of the cycle: freq_word←freq, amp←amp, cnt←max(dur,1), seg_idx←idx; go to RUN.
  - dds_en=0 on the first LOAD after start; dds_en=1 on inter-segment LOADs (carrier continuous).
  - freq_word/amp keep the previous segment's values during an inter-segment LOAD.
- RUN:
  - busy=1, dds_en=1; cnt decrements every cycle.
  - When cnt==1:
    - If entry[idx].last=0 and idx≠DEPTH-1: idx←idx+1, go to LOAD.
    - Else if loop_en=1: idx←0, go to LOAD.
    - Else go to DONE.
- DONE (one cycle): done=1, busy=0, dds_en=0, amp=0; go to IDLE.
- Segment timing:
  - Each segment occupies exactly 1 LOAD + max(dur,1) RUN cycles.
  - Latency from the start edge to the first RUN cycle (dds_en=1, outputs valid) is 2 cycles.
- loop_en is sampled only at the wrap decision; deasserting it mid-sequence ends the sequence after the current pass.
- If no entry has last=1, the sequence ends after entry DEPTH-1 (or wraps if loop_en=1).
- stop=1 at any edge in LOAD, RUN or DONE:
  - Go to IDLE next cycle: dds_en=0, amp=0, busy=0, no done pulse.
  - freq_word and seg_idx hold their values.
- Simultaneous start and stop in IDLE: stop wins, remain IDLE.
- start while busy is ignored; no restart.
- start held high through DONE re-launches from IDLE on the following edge.
- Async rst mid-sequence forces all outputs to 0 and the table to 0 immediately, with no done pulse.
- Arithmetic: cnt is an unsigned DUR_W-bit value; max(dur,1) is implemented as a substitution of 1 when dur==0, with no wraparound.

Test Plan:
- Reset: assert rst mid-RUN → all outputs 0 in the same cycle; after release, reading back playback shows the table cleared (start yields one segment with freq 0, amp 0, dur 1, then on to entry 1).
- One-shot with three entries:
  - Entries: {1678, 0x4000, 5, 0}, {168, 0x8000, 3, 0}, {1678, 0x2000, 2, 1}; pulse start.
  - Required: dds_en rises 2 cycles after start; freq_word=1678 for 5 RUN cycles, then 1 LOAD, then 168 for 3, then 1678 for 2.
  - Then a done pulse, busy low; total busy = 13 cycles.
- Loop:
  - Same table, loop_en=1 → seg_idx sequence 0,1,2,0,1,…; dds_en never drops.
  - Deassert loop_en during entry 1 → completes entry 2, then done.
- Stop: stop asserted in the 2nd RUN cycle of entry 1 → next cycle IDLE, amp=0, dds_en=0, no done; freq_word stays 168.
- Boundary:
  - Entry with dur=0 runs 1 cycle.
  - Table with no last bit set: runs entries 0–7 then done.
  - start+stop in the same IDLE cycle: stays IDLE.
- Config rejection: cfg_we to addr 1 while busy → cfg_err pulse one cycle later; entry 1 unchanged on the next playback.
